// File: rtl/score_display_scan_ctrl_if.sv
// Score/display bundle between the game-logic score registers and the
// 7-segment scan controller; master drives scores, slave drives the pins.
interface score_display_scan_ctrl_if;
   logic       en;
   logic [3:0] p1_score;
   logic [3:0] p2_score;
   logic [1:0] winner;
   logic [6:0] seg;
   logic [3:0] an;
   logic [1:0] sel;

   modport master (
      output en, p1_score, p2_score, winner,
      input  seg, an, sel
   );

   modport slave (
      input  en, p1_score, p2_score, winner,
      output seg, an, sel
   );
endinterface

// File: rtl/score_display_scan_ctrl.sv
// 4-digit 7-segment scan controller for the Pong score: P1 on digit 0, P2 on
// digit 3, dashes between, with change-blink and winner-blink on player digits.
module score_display_scan_ctrl #(
   parameter int REFRESH_DIV  = 100000,
   parameter int GUARD        = 2,
   parameter int BLINK_FRAMES = 32,
   parameter int BLINK_BIT    = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   score_display_scan_ctrl_if.slave  bus
);

   localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int FW = BLINK_BIT + 1;
   localparam int BW = $clog2(BLINK_FRAMES + 1);

   localparam logic [6:0] SEG_DASH = 7'b1111110;

   typedef enum logic [1:0] {
      SLOT_P1      = 2'd0,
      SLOT_DASH_LO = 2'd1,
      SLOT_DASH_HI = 2'd2,
      SLOT_P2      = 2'd3
   } slot_e;

   logic [TW-1:0] r_tick;
   slot_e         r_slot;
   logic [FW-1:0] r_frm;
   logic [BW-1:0] r_blink1;
   logic [BW-1:0] r_blink2;
   logic [3:0]    r_prev1;
   logic [3:0]    r_prev2;
   logic [6:0]    r_seg;
   logic [3:0]    r_an;

   logic          w_tc;
   logic          w_frame_end;
   logic          w_chg1;
   logic          w_chg2;
   logic          w_blank1;
   logic          w_blank2;
   logic [6:0]    w_seg_nxt;
   logic [3:0]    w_an_nxt;

   function automatic logic [6:0] f_decode(input logic [3:0] v);
      case (v)
         4'd0:    f_decode = 7'b0000001;
         4'd1:    f_decode = 7'b1001111;
         4'd2:    f_decode = 7'b0010010;
         4'd3:    f_decode = 7'b0000110;
         4'd4:    f_decode = 7'b1001100;
         4'd5:    f_decode = 7'b0100100;
         4'd6:    f_decode = 7'b0100000;
         4'd7:    f_decode = 7'b0001111;
         4'd8:    f_decode = 7'b0000000;
         4'd9:    f_decode = 7'b0000100;
         default: f_decode = SEG_DASH;
      endcase
   endfunction

   always_comb begin
      w_tc        = (r_tick == TW'(REFRESH_DIV - 1));
      w_frame_end = w_tc && (r_slot == SLOT_P2);
      w_chg1      = (bus.p1_score != r_prev1);
      w_chg2      = (bus.p2_score != r_prev2);
      w_blank1    = r_frm[BLINK_BIT] && ((r_blink1 != '0) || (bus.winner == 2'd1));
      w_blank2    = r_frm[BLINK_BIT] && ((r_blink2 != '0) || (bus.winner == 2'd2));
      w_seg_nxt   = '1;
      w_an_nxt    = '1;
      if (bus.en) begin
         case (r_slot)
            SLOT_P1: w_seg_nxt = w_blank1 ? 7'h7F : f_decode(bus.p1_score);
            SLOT_P2: w_seg_nxt = w_blank2 ? 7'h7F : f_decode(bus.p2_score);
            default: w_seg_nxt = SEG_DASH;
         endcase
         // Anodes stay dark for the first GUARD clocks of each slot to hide ghosting.
         if (r_tick >= TW'(GUARD)) w_an_nxt = ~(4'b0001 << r_slot);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tick   <= '0;
         r_slot   <= SLOT_P1;
         r_frm    <= '0;
         r_blink1 <= '0;
         r_blink2 <= '0;
         r_prev1  <= bus.p1_score;
         r_prev2  <= bus.p2_score;
         r_seg    <= '1;
         r_an     <= '1;
      end else begin
         r_tick <= w_tc ? '0 : r_tick + 1'b1;
         if (w_tc) r_slot <= slot_e'(r_slot + 2'd1);
         if (w_frame_end) r_frm <= r_frm + 1'b1;
         // A score change overrides a coincident frame-end decrement with a full reload.
         if (w_chg1) begin
            r_blink1 <= BW'(BLINK_FRAMES);
            r_prev1  <= bus.p1_score;
         end else if (w_frame_end && (r_blink1 != '0)) begin
            r_blink1 <= r_blink1 - 1'b1;
         end
         if (w_chg2) begin
            r_blink2 <= BW'(BLINK_FRAMES);
            r_prev2  <= bus.p2_score;
         end else if (w_frame_end && (r_blink2 != '0)) begin
            r_blink2 <= r_blink2 - 1'b1;
         end
         r_seg <= w_seg_nxt;
         r_an  <= w_an_nxt;
      end
   end

   assign bus.seg = r_seg;
   assign bus.an  = r_an;
   assign bus.sel = r_slot;

endmodule

// File: tb/tb_score_display_scan_ctrl.sv
// Directed bench for score_display_scan_ctrl: decode table, scan timing,
// blink/winner behaviour, enable gating, reset mid-slot and random invariants.
module tb_score_display_scan_ctrl;

   localparam int RD = 4;
   localparam int GD = 1;
   localparam int BF = 4;
   localparam int BB = 0;

   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] DASH  = 7'b1111110;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   score_display_scan_ctrl_if bus_if ();

   score_display_scan_ctrl #(
      .REFRESH_DIV  (RD),
      .GUARD        (GD),
      .BLINK_FRAMES (BF),
      .BLINK_BIT    (BB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   typedef struct packed {
      logic [3:0] p1;
      logic [3:0] p2;
      logic [6:0] exp1;
      logic [6:0] exp2;
   } dec_vec_t;

   dec_vec_t   dec_tab [16];
   logic [3:0] an_tab  [4];
   logic [6:0] t1_seg  [4];

   int   checks = 0;
   int   errors = 0;
   int   m_tick, m_sel, m_frm, m_ptick, m_psel, m_pfrm;
   logic p_en, p_reset;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b", nm, act, exp);
      end
   endtask

   // One clock: remember pre-edge state, advance, then update the counter model.
   task automatic step();
      p_en    = bus_if.en;
      p_reset = reset;
      m_ptick = m_tick;
      m_psel  = m_sel;
      m_pfrm  = m_frm;
      @(posedge clk);
      #1;
      if (p_reset) begin
         m_tick = 0; m_sel = 0; m_frm = 0;
      end else if (m_tick == RD - 1) begin
         m_tick = 0;
         if (m_sel == 3) m_frm++;
         m_sel = (m_sel + 1) % 4;
      end else begin
         m_tick++;
      end
   endtask

   // f: -1 any frame, -2 any even frame, otherwise exact frame number
   task automatic wait_post(input int s, input int t, input int f);
      int n;
      n = 0;
      while (!(m_sel == s && m_tick == t &&
               (f == -1 || (f == -2 && m_frm % 2 == 0) || m_frm == f))) begin
         if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_s%0d_t%0d got timeout want reached", s, t);
            return;
         end
         step();
         n++;
      end
   endtask

   task automatic check_frame(input string nm, input logic [6:0] e0e, input logic [6:0] e0o,
                              input logic [6:0] e3e, input logic [6:0] e3o);
      wait_post(0, 3, -1);
      chk({nm, "_d0_seg"}, 8'(bus_if.seg), 8'((m_pfrm % 2 == 1) ? e0o : e0e));
      chk({nm, "_d0_an"},  8'(bus_if.an),  8'(4'b1110));
      wait_post(3, 3, -1);
      chk({nm, "_d3_seg"}, 8'(bus_if.seg), 8'((m_pfrm % 2 == 1) ? e3o : e3e));
      chk({nm, "_d3_an"},  8'(bus_if.an),  8'(4'b0111));
   endtask

   initial begin
      dec_tab[0]  = '{4'd0,  4'd15, 7'b0000001, DASH};
      dec_tab[1]  = '{4'd1,  4'd14, 7'b1001111, DASH};
      dec_tab[2]  = '{4'd2,  4'd13, 7'b0010010, DASH};
      dec_tab[3]  = '{4'd3,  4'd12, 7'b0000110, DASH};
      dec_tab[4]  = '{4'd4,  4'd11, 7'b1001100, DASH};
      dec_tab[5]  = '{4'd5,  4'd10, 7'b0100100, DASH};
      dec_tab[6]  = '{4'd6,  4'd9,  7'b0100000, 7'b0000100};
      dec_tab[7]  = '{4'd7,  4'd8,  7'b0001111, 7'b0000000};
      dec_tab[8]  = '{4'd8,  4'd7,  7'b0000000, 7'b0001111};
      dec_tab[9]  = '{4'd9,  4'd6,  7'b0000100, 7'b0100000};
      dec_tab[10] = '{4'd10, 4'd5,  DASH,       7'b0100100};
      dec_tab[11] = '{4'd11, 4'd4,  DASH,       7'b1001100};
      dec_tab[12] = '{4'd12, 4'd3,  DASH,       7'b0000110};
      dec_tab[13] = '{4'd13, 4'd2,  DASH,       7'b0010010};
      dec_tab[14] = '{4'd14, 4'd1,  DASH,       7'b1001111};
      dec_tab[15] = '{4'd15, 4'd0,  DASH,       7'b0000001};
      an_tab      = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      t1_seg      = '{7'b0000110, DASH, DASH, 7'b0001111};

      m_tick = 0; m_sel = 0; m_frm = 0;
      reset           = 1'b1;
      bus_if.en       = 1'b1;
      bus_if.p1_score = 4'd3;
      bus_if.p2_score = 4'd7;
      bus_if.winner   = 2'd0;

      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_an",  8'(bus_if.an),  8'(4'b1111));
         chk("rst_seg", 8'(bus_if.seg), 8'(BLANK));
         chk("rst_sel", 8'(bus_if.sel), 8'(2'd0));
      end
      reset = 1'b0;

      // First frame after reset: guard clock then three lit clocks per slot.
      for (int j = 0; j < 16; j++) begin
         step();
         chk("scan_an",  8'(bus_if.an),  8'((j % 4 == 0) ? 4'b1111 : an_tab[j / 4]));
         chk("scan_seg", 8'(bus_if.seg), 8'(t1_seg[j / 4]));
      end

      // Change-blink on P1: odd frames blanked while counter nonzero.
      wait_post(0, 0, 2);
      bus_if.p1_score = 4'd4;
      for (int f = 2; f < 8; f++) begin
         logic [6:0] e0;
         e0 = (f == 3 || f == 5) ? BLANK : 7'b1001100;
         check_frame("blink1", e0, e0, 7'b0001111, 7'b0001111);
      end

      for (int i = 0; i < 16; i++) begin
         bus_if.p1_score = dec_tab[i].p1;
         bus_if.p2_score = dec_tab[i].p2;
         wait_post(0, 0, -2);
         check_frame("decode", dec_tab[i].exp1, BLANK, dec_tab[i].exp2, BLANK);
      end

      bus_if.p1_score = 4'd4;
      bus_if.p2_score = 4'd12;
      wait_post(0, 0, -2);
      check_frame("p2_dash", 7'b1001100, BLANK, DASH, BLANK);

      wait_post(1, 2, -1);
      bus_if.en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("en_off_an",  8'(bus_if.an),  8'(4'b1111));
         chk("en_off_seg", 8'(bus_if.seg), 8'(BLANK));
      end
      chk("en_off_sel", 8'(bus_if.sel), 8'(2'd2));
      bus_if.en = 1'b1;
      step();
      chk("en_on_an",  8'(bus_if.an),  8'(4'b1011));
      chk("en_on_seg", 8'(bus_if.seg), 8'(DASH));
      chk("en_on_sel", 8'(bus_if.sel), 8'(2'd3));
      step();
      chk("en_on_guard", 8'(bus_if.an), 8'(4'b1111));
      step();
      chk("en_on_an3", 8'(bus_if.an), 8'(4'b0111));

      for (int i = 0; i < 80; i++) step();
      bus_if.winner = 2'd2;
      for (int i = 0; i < 8; i++) check_frame("win2", 7'b1001100, 7'b1001100, DASH, BLANK);
      bus_if.winner = 2'd3;
      for (int i = 0; i < 2; i++) check_frame("win3", 7'b1001100, 7'b1001100, DASH, DASH);
      bus_if.winner = 2'd1;
      for (int i = 0; i < 2; i++) check_frame("win1", 7'b1001100, BLANK, DASH, DASH);
      bus_if.winner = 2'd0;

      // Second change lands exactly on the frame-end edge that would take blink1 1->0.
      begin
         int fb;
         wait_post(0, 0, -2);
         fb = m_frm;
         bus_if.p1_score = 4'd5;
         wait_post(3, 3, fb + 3);
         bus_if.p1_score = 4'd6;
         for (int k = 4; k < 10; k++) begin
            logic [6:0] e0;
            e0 = (k % 2 == 1 && k <= 7) ? BLANK : 7'b0100000;
            check_frame("reload", e0, e0, DASH, DASH);
         end
      end

      wait_post(0, 0, -1);
      bus_if.p1_score = 4'd7;
      wait_post(2, 1, -1);
      reset = 1'b1;
      step();
      chk("midrst_an",  8'(bus_if.an),  8'(4'b1111));
      chk("midrst_seg", 8'(bus_if.seg), 8'(BLANK));
      chk("midrst_sel", 8'(bus_if.sel), 8'(2'd0));
      reset = 1'b0;
      check_frame("postrst", 7'b0001111, 7'b0001111, DASH, DASH);
      check_frame("postrst", 7'b0001111, 7'b0001111, DASH, DASH);

      for (int i = 0; i < 1000; i++) begin
         step();
         chk("rnd_sel", 8'(bus_if.sel), 8'(m_sel));
         chk("rnd_onehot", 8'($countones(~bus_if.an) <= 1), 8'(1));
         if (!p_en || m_ptick < GD) chk("rnd_an_off", 8'(bus_if.an), 8'(4'b1111));
         else                       chk("rnd_an_on",  8'(bus_if.an), 8'(an_tab[m_psel]));
         if (!p_en) chk("rnd_seg_off", 8'(bus_if.seg), 8'(BLANK));
         if ($urandom_range(0, 7) == 0) bus_if.p1_score = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) bus_if.p2_score = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) bus_if.winner = 2'($urandom_range(0, 3));
         bus_if.en = ($urandom_range(0, 9) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
